fir_decim_buffer: RTL and testbench

- Downstream consumer of the FIR filter stage. Samples the FIR's registered output one cycle after each enable strobe, discards pipeline-fill samples after reset or clear, and decimates by DECIM.
- Buffers decimated samples in a small FIFO and presents them on a valid/ready interface to the next stage, typically a packer or bus bridge.

---
 rtl/fir_decim_buffer_if.sv | 21 ++
 rtl/fir_decim_buffer.sv | 127 ++++++++++++
 tb/tb_fir_decim_buffer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fir_decim_buffer_if.sv
// Valid/ready output stream of the FIR decimation buffer.
// The buffer drives it through the master modport; the next stage uses the slave modport.
interface fir_decim_buffer_if #(
  parameter int WIDTH = 9
);
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_data;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/fir_decim_buffer.sv
// Captures the FIR output one cycle after each enable and drops the pipeline-fill samples.
// It then decimates by DECIM and queues the kept samples in a small FIFO for a valid/ready consumer.
module fir_decim_buffer #(
  parameter int WIDTH = 9,
  parameter int DECIM = 4,
  parameter int FILL  = 3,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic                      en,
  input  logic                      clr,
  input  logic signed [WIDTH-1:0]   data_in,
  fir_decim_buffer_if.master        out_if,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int FCW = (FILL > 1) ? $clog2(FILL) : 1;
  localparam int PW  = (DECIM > 1) ? $clog2(DECIM) : 1;

  typedef enum logic {
    ST_FILL,
    ST_RUN
  } state_t;

  localparam state_t START_STATE = (FILL == 0) ? ST_RUN : ST_FILL;

  logic                    en_d;
  state_t                  state_q, state_d;
  logic [FCW-1:0]          fill_q, fill_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic                    push, pop, push_ok;
  logic signed [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count;
  logic signed [WIDTH-1:0] last_q;

  // FIR data_out changes on the en edge, so the sample is valid in the cycle after en.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    phase_d = phase_q;
    push    = 1'b0;
    if (en_d) begin
      unique case (state_q)
        ST_FILL: begin
          if (int'(fill_q) == FILL - 1) begin
            state_d = ST_RUN;
            fill_d  = '0;
            phase_d = '0;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
        ST_RUN: begin
          push    = (phase_q == '0);
          phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pop     = out_if.out_valid && out_if.out_ready;
  assign push_ok = push && ((count < CW'(DEPTH)) || pop);

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      en_d     <= 1'b0;
      state_q  <= START_STATE;
      fill_q   <= '0;
      phase_q  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      last_q   <= '0;
    end else begin
      en_d <= en;
      // A flush wins over any push or pop presented in the same cycle.
      if (clr) begin
        state_q  <= START_STATE;
        fill_q   <= '0;
        phase_q  <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
        last_q   <= '0;
      end else begin
        state_q <= state_d;
        fill_q  <= fill_d;
        phase_q <= phase_d;
        if (push_ok) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
          last_q <= mem[rd_ptr];
        end
        if (push_ok && !pop) begin
          count <= count + 1'b1;
        end else if (pop && !push_ok) begin
          count <= count - 1'b1;
        end
        if (push && !push_ok) begin
          overflow <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_b && !clr && push_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // An empty FIFO keeps showing the last value handed downstream.
  assign out_if.out_valid = (count != '0);
  assign out_if.out_data  = out_if.out_valid ? mem[rd_ptr] : last_q;
  assign level            = count;

endmodule

// File: tb/tb_fir_decim_buffer.sv
// Directed bench for fir_decim_buffer: hand-computed expected samples go into queues.
// Monitors pop those queues whenever a sample is accepted downstream.
module tb_fir_decim_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_b;
  logic              en;
  logic              clr;
  logic              clr1;
  logic signed [8:0] data_in;
  logic [2:0]        level0, level1;
  logic              ovf0, ovf1;

  fir_decim_buffer_if #(.WIDTH(9)) if0 ();
  fir_decim_buffer_if #(.WIDTH(9)) if1 ();

  fir_decim_buffer #(.WIDTH(9), .DECIM(4), .FILL(3), .DEPTH(4)) u_dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .en       (en),
    .clr      (clr),
    .data_in  (data_in),
    .out_if   (if0.master),
    .level    (level0),
    .overflow (ovf0)
  );

  fir_decim_buffer #(.WIDTH(9), .DECIM(1), .FILL(3), .DEPTH(4)) u_dut1 (
    .clk      (clk),
    .rst_b    (rst_b),
    .en       (en),
    .clr      (clr1),
    .data_in  (data_in),
    .out_if   (if1.master),
    .level    (level1),
    .overflow (ovf1)
  );

  int vectors     = 0;
  int miscompares = 0;
  int exp_q[$];
  int exp1_q[$];

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic signed [8:0] d, input int n);
    en      = e;
    data_in = d;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // en in one cycle, the FIR result on data_in the next, then optional idle cycles.
  task automatic capture(input logic signed [8:0] v, input int gap);
    applyStimulus(1'b1, 9'sd0, 1);
    applyStimulus(1'b0, v, 1);
    if (gap > 0) applyStimulus(1'b0, 9'sd0, gap);
  endtask

  task automatic restart();
    clr = 1'b1;
    applyStimulus(1'b0, 9'sd0, 2);
    clr = 1'b0;
    for (int i = 0; i < 3; i++) capture(9'(100 + i), 0);
    checkOutput("fill_discard_level", int'(level0), 0);
  endtask

  task automatic drain(input int n);
    if0.out_ready = 1'b1;
    applyStimulus(1'b0, 9'sd0, n);
    checkOutput("drain_queue_empty", exp_q.size(), 0);
    checkOutput("drain_level", int'(level0), 0);
  endtask

  always @(negedge clk) begin
    if (rst_b === 1'b1 && clr === 1'b0 && if0.out_valid === 1'b1 && if0.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL out_data unexpected: got %0d, expected no sample", int'(if0.out_data));
      end else begin
        checkOutput("out_data", int'(if0.out_data), exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_b === 1'b1 && clr1 === 1'b0 && if1.out_valid === 1'b1 && if1.out_ready === 1'b1) begin
      if (exp1_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL out_data1 unexpected: got %0d, expected no sample", int'(if1.out_data));
      end else begin
        checkOutput("out_data1", int'(if1.out_data), exp1_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sparse_vals[5];
    sparse_vals = '{-256, 255, -1, 7, -100};

    rst_b = 1'b0; en = 1'b0; clr = 1'b0; clr1 = 1'b1; data_in = '0;
    if0.out_ready = 1'b0;
    if1.out_ready = 1'b1;
    applyStimulus(1'b0, 9'sd0, 3);
    checkOutput("rst_level", int'(level0), 0);
    checkOutput("rst_valid", int'(if0.out_valid), 0);
    checkOutput("rst_data", int'(if0.out_data), 0);
    checkOutput("rst_overflow", int'(ovf0), 0);
    rst_b = 1'b1;

    // Ramp with en every cycle: captures 1..3 discarded, then every 4th kept.
    if0.out_ready = 1'b1;
    exp_q.push_back(4); exp_q.push_back(8); exp_q.push_back(12); exp_q.push_back(16);
    for (int k = 0; k <= 16; k++) begin
      applyStimulus(1'b1, 9'(k), 1);
      if (k == 3) checkOutput("latency_not_yet_valid", int'(if0.out_valid), 0);
      if (k == 4) begin
        checkOutput("latency_valid", int'(if0.out_valid), 1);
        checkOutput("first_pushed", int'(if0.out_data), 4);
      end
    end
    applyStimulus(1'b0, 9'sd17, 1);
    drain(4);
    checkOutput("ramp_overflow", int'(ovf0), 0);

    // Backpressure: four kept samples fill the FIFO, the fifth is dropped.
    restart();
    if0.out_ready = 1'b0;
    exp_q.push_back(20); exp_q.push_back(24); exp_q.push_back(28); exp_q.push_back(32);
    for (int i = 0; i <= 16; i++) begin
      capture(9'(20 + i), 0);
      if (i % 4 == 0 && i < 16) checkOutput("bp_level", int'(level0), i / 4 + 1);
      if (i == 12) checkOutput("bp_overflow_clear", int'(ovf0), 0);
    end
    checkOutput("bp_full_level", int'(level0), 4);
    checkOutput("bp_overflow_set", int'(ovf0), 1);
    checkOutput("bp_head_stable", int'(if0.out_data), 20);
    drain(6);
    checkOutput("bp_overflow_sticky", int'(ovf0), 1);

    // Full FIFO with a pop in the same cycle as a push.
    restart();
    if0.out_ready = 1'b0;
    for (int i = 0; i <= 16; i += 4) exp_q.push_back(40 + i);
    for (int i = 0; i <= 15; i++) capture(9'(40 + i), 0);
    checkOutput("full_level", int'(level0), 4);
    applyStimulus(1'b1, 9'sd0, 1);
    if0.out_ready = 1'b1;
    applyStimulus(1'b0, 9'sd56, 1);
    if0.out_ready = 1'b0;
    checkOutput("full_pushpop_level", int'(level0), 4);
    checkOutput("full_pushpop_overflow", int'(ovf0), 0);
    checkOutput("full_pushpop_head", int'(if0.out_data), 44);
    drain(6);

    // Sparse en on the DECIM=1 instance, every third cycle.
    clr = 1'b1;
    clr1 = 1'b0;
    for (int i = 0; i < 5; i++) exp1_q.push_back(sparse_vals[i]);
    for (int i = 0; i < 3; i++) capture(9'(1 + i), 1);
    checkOutput("sparse_fill_level", int'(level1), 0);
    for (int i = 0; i < 5; i++) capture(9'(sparse_vals[i]), 1);
    applyStimulus(1'b0, 9'sd0, 3);
    checkOutput("sparse_queue_empty", exp1_q.size(), 0);
    checkOutput("sparse_valid_low", int'(if1.out_valid), 0);
    checkOutput("sparse_hold_last", int'(if1.out_data), -100);
    checkOutput("sparse_overflow", int'(ovf1), 0);
    clr1 = 1'b1;
    clr = 1'b0;

    // clr while level=3, overflow=1 and a push and pop coincide.
    restart();
    if0.out_ready = 1'b0;
    exp_q.push_back(60); exp_q.push_back(64); exp_q.push_back(68); exp_q.push_back(72);
    for (int i = 0; i <= 16; i++) capture(9'(60 + i), 0);
    checkOutput("clr_pre_overflow", int'(ovf0), 1);
    if0.out_ready = 1'b1;
    applyStimulus(1'b0, 9'sd0, 1);
    if0.out_ready = 1'b0;
    for (int i = 17; i <= 19; i++) capture(9'(60 + i), 0);
    checkOutput("clr_pre_level", int'(level0), 3);
    applyStimulus(1'b1, 9'sd0, 1);
    clr = 1'b1;
    if0.out_ready = 1'b1;
    applyStimulus(1'b0, 9'sd80, 1);
    clr = 1'b0;
    checkOutput("clr_level", int'(level0), 0);
    checkOutput("clr_valid", int'(if0.out_valid), 0);
    checkOutput("clr_overflow", int'(ovf0), 0);
    checkOutput("clr_data", int'(if0.out_data), 0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) capture(9'(90 + i), 0);
    checkOutput("clr_refill_level", int'(level0), 0);
    if0.out_ready = 1'b0;
    exp_q.push_back(93);
    capture(9'sd93, 0);
    checkOutput("clr_first_push_level", int'(level0), 1);
    checkOutput("clr_first_push_data", int'(if0.out_data), 93);

    // Reset while out_valid=1 and en active.
    rst_b = 1'b0;
    applyStimulus(1'b1, 9'sd55, 1);
    checkOutput("midrst_level", int'(level0), 0);
    checkOutput("midrst_valid", int'(if0.out_valid), 0);
    checkOutput("midrst_overflow", int'(ovf0), 0);
    checkOutput("midrst_data", int'(if0.out_data), 0);
    exp_q.delete();
    rst_b = 1'b1;
    for (int i = 0; i < 3; i++) capture(9'(101 + i), 0);
    checkOutput("midrst_refill_level", int'(level0), 0);
    exp_q.push_back(110);
    if0.out_ready = 1'b1;
    capture(9'sd110, 0);
    drain(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
